// File: rtl/seq_subtractor.sv
`timescale 1ns/1ps
// seq_subtractor
// ----------------------------------------------------------------------------
// Multi-cycle subtractor computing a - b - bin over WIDTH bits, DIGIT bits per
// clock, least-significant digit first. The borrow ripples between cycles
// through a single flop.
//
// Handshake: start is a request that is taken on any rising edge where the
// unit is IDLE or DONE (the "ready" condition). There is no backpressure on
// the result side. done is a one-cycle pulse that marks diff/bout/ovf/zero as
// valid. The unit ignores start while busy, so a caller that wants a result
// must raise start only when busy is low.
//
// Parameters
//   WIDTH    operand width in bits (>= 2)
//   DIGIT    bits per cycle, must divide WIDTH
//   SATURATE 0: wrap-around diff, 1: diff clamps to 0 on final borrow
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        operation request
//   a, b, bin    minuend, subtrahend, borrow-in (captured on accepted start)
//   busy         digit cycles in progress
//   done         one-cycle result-valid pulse
//   diff         result (held until the next completion)
//   bout         borrow out of the MSB (unsigned underflow)
//   ovf          signed two's-complement overflow
//   zero         diff == 0
//   state_dbg    current FSM state (0 IDLE, 1 RUN, 2 DONE) for checkers
// ----------------------------------------------------------------------------
module seq_subtractor #(
  parameter int WIDTH    = 16,
  parameter int DIGIT    = 4,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] acc_q;
  logic             borrow_q;
  logic [CW-1:0]    cnt_q;

  // Digit datapath signals
  logic [DIGIT-1:0] slice_a;
  logic [DIGIT-1:0] slice_b;
  logic [DIGIT-1:0] slice_res;
  logic [DIGIT:0]   slice_full;
  logic             borrow_next;
  logic             ovf_next;
  logic             last;
  logic             accept;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] diff_next;

  // Operands are shifted right each cycle, so the active digit always sits
  // in the low DIGIT bits.
  assign slice_a     = a_q[DIGIT-1:0];
  assign slice_b     = b_q[DIGIT-1:0];
  assign slice_full  = {1'b0, slice_a} - {1'b0, slice_b} - {{DIGIT{1'b0}}, borrow_q};
  assign slice_res   = slice_full[DIGIT-1:0];
  assign borrow_next = slice_full[DIGIT];

  // Result digits enter at the top and move down, so after N cycles the
  // first digit has reached bit 0.
  assign acc_next = (acc_q >> DIGIT) | (WIDTH'(slice_res) << (WIDTH - DIGIT));

  // For a subtractor bit, res = a ^ b ^ borrow_in, so the borrow into the
  // MSB is recovered from the MSB operand and result bits.
  assign ovf_next = slice_a[DIGIT-1] ^ slice_b[DIGIT-1] ^ slice_res[DIGIT-1] ^ borrow_next;

  assign diff_next = ((SATURATE != 0) && borrow_next) ? '0 : acc_next;

  assign last   = (cnt_q == CW'(N - 1));
  assign accept = start && ((state_q == IDLE) || (state_q == DONE));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (last)  state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      ovf      <= 1'b0;
      zero     <= 1'b1;
    end else if (accept) begin
      a_q      <= a;
      b_q      <= b;
      acc_q    <= '0;
      borrow_q <= bin;
      cnt_q    <= '0;
    end else if (state_q == RUN) begin
      a_q      <= a_q >> DIGIT;
      b_q      <= b_q >> DIGIT;
      acc_q    <= acc_next;
      borrow_q <= borrow_next;
      cnt_q    <= cnt_q + CW'(1);
      if (last) begin
        diff <= diff_next;
        bout <= borrow_next;
        ovf  <= ovf_next;
        zero <= (diff_next == '0);
      end
    end
  end

  // Pure decodes of the state register: no path from inputs.
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign state_dbg = state_q;

endmodule

// File: doc/seq_subtractor.md
# seq_subtractor

Parametrised, multi-cycle subtractor computing `a - b - bin` over `WIDTH` bits, `DIGIT` bits per clock, LSB digit first, with a borrow chain carried between cycles. It generalises the 1-bit full subtractor into a word-level arithmetic unit with:

- start/busy/done handshake,
- signed-overflow and zero flags,
- optional unsigned saturation.

It sits in the datapath wherever a wide subtract is needed and area matters more than latency.

## Interface
Parameters:
- `WIDTH`, 16: operand width in bits; must be ≥ 2.
- `DIGIT`, 4: bits processed per cycle; must divide `WIDTH` (1 ≤ `DIGIT` ≤ `WIDTH`).
- `SATURATE`, 0: 0 = wrap-around result; 1 = unsigned clamp to 0 on final borrow.

Ports:
- `clk`, in, 1: clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: request; sampled at the rising edge while idle or done.
- `a`, in, `WIDTH`: minuend; captured on an accepted start.
- `b`, in, `WIDTH`: subtrahend; captured on an accepted start.
- `bin`, in, 1: borrow-in; captured on an accepted start.
- `busy`, out, 1: operation in progress.
- `done`, out, 1: one-cycle pulse; result outputs valid.
- `diff`, out, `WIDTH`: result.
- `bout`, out, 1: borrow out of the MSB (unsigned underflow).
- `ovf`, out, 1: signed two's-complement overflow.
- `zero`, out, 1: `diff` output equals 0.

## Operation
- N = `WIDTH`/`DIGIT` digit cycles.
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1: capture `a`, `b`, `bin` into internal registers; clear the digit counter; go to RUN.
  - Otherwise stay in IDLE.
- **RUN**, each edge:
  - Compute one `DIGIT`-bit slice `a_i - b_i - borrow`, starting from the LSB digit.
  - Shift the slice into the result accumulator.
  - Update the internal borrow and increment the counter.
  - At the edge processing digit N-1, go to DONE and register the outputs in that same edge:
    - `bout` = final borrow.
    - `ovf` = borrow into MSB XOR borrow out of MSB.
    - `diff` = raw result, or 0 if `SATURATE`=1 and `bout`=1.
    - `zero` = (registered `diff` == 0).
- **DONE** (one cycle)
  - `start`=1: accept a new operation, same as IDLE, and go to RUN (back-to-back).
  - Otherwise go to IDLE.
- `start` while in RUN is ignored; it is neither queued nor corrupting.
- `diff`, `bout`, `ovf`, `zero` update only on the completion edge. They hold their value through IDLE and through the RUN phase of the next operation.
- Inputs `a`, `b`, `bin` may change freely after the start edge.
- `DIGIT`=`WIDTH` is legal: single RUN cycle. `DIGIT`=1 is fully bit-serial.
- `ovf` is reported in both `SATURATE` modes. Saturation affects only `diff` and `zero`.

## Timing
- Reset (asynchronous on `rst_n` low, regardless of state):
  - State goes to IDLE.
  - `busy`=0, `done`=0, `diff`=0, `bout`=0, `ovf`=0, `zero`=1.
  - Internal registers are cleared.
- Reset mid-RUN aborts the operation. No `done` is produced.
- Release is synchronous to `clk`: the first `start` is accepted at the first rising edge with `rst_n` high.
- Latency: start accepted at edge E0.
  - `busy`=1 from after E0 until edge E0+N.
  - `done`=1 and results valid for exactly the cycle after edge E0+N.
- Throughput with back-to-back starts: one result every N+1 cycles.
- `busy` and `done` are never high simultaneously.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
- **Basic subtract** (`WIDTH`=16, `DIGIT`=4): `a`=0x1234, `b`=0x0234, `bin`=0 → `diff`=0x1000, `bout`=0, `ovf`=0, `zero`=0. `done` follows exactly 4 cycles after the start edge. `busy` is high for 4 cycles.
- **Underflow, wrap vs saturate**: `a`=0x0000, `b`=0x0001, `bin`=0.
  - `SATURATE`=0 → `diff`=0xFFFF, `bout`=1, `ovf`=0, `zero`=0.
  - `SATURATE`=1 → `diff`=0x0000, `bout`=1, `zero`=1.
- **Signed overflow and borrow-in**:
  - `a`=0x8000, `b`=0x0001 → `diff`=0x7FFF, `ovf`=1, `bout`=0.
  - `a`=0x0005, `b`=0x0005, `bin`=1 → `diff`=0xFFFF, `bout`=1, `ovf`=0.
- **Handshake**:
  - Pulse `start` again during RUN with different operands; verify it is ignored and the first result is unchanged.
  - Assert `start` in the DONE cycle; verify the next `done` arrives N+1 cycles after the previous one.
- **Reset**:
  - Drop `rst_n` two cycles into RUN → all outputs go to reset values immediately (asynchronously); no `done` pulse.
  - A new operation after release completes correctly.
- **Exhaustive truth** (`WIDTH`=4, `DIGIT`=1 and `DIGIT`=4): all 512 combinations of `a`, `b`, `bin`. Compare `diff`, `bout`, `ovf` against the reference `(a - b - bin) mod 16`, the borrow, and signed-overflow. The `DIGIT`=1 LSB slice must match the 1-bit full-subtractor truth table.
